// File: rtl/store_narrow_unit.sv
// Store narrowing unit: narrows a register value to byte/half/word, merges it into
// word-wide data memory (read-modify-write for sub-word stores) and reports trunc_ok.
module store_narrow_unit #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  input  logic [1:0]        size,
  input  logic              ExtOp,
  output logic              busy,
  output logic              done,
  output logic              misaligned,
  output logic              trunc_ok,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [31:0]       mem_rdata,
  output logic              mem_wr,
  output logic [31:0]       mem_wdata
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_MRG  = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  logic [2:0]  state_r;
  logic [2:0]  state_nx_s;
  logic [1:0]  addr_lo_r;
  logic [31:0] wdata_r;
  logic [1:0]  size_r;
  logic        extop_r;
  logic        misal_r;
  logic        misal_s;
  logic        unused_addr_s;

  assign unused_addr_s = ^addr[31:ADDR_W+2];

  // Replace the addressed little-endian lane of the old word with the narrowed value.
  function automatic logic [31:0] merge_lane(input logic [31:0] old_w,
                                             input logic [31:0] new_v,
                                             input logic [1:0]  sz,
                                             input logic [1:0]  lo);
    logic [31:0] res;
    res = old_w;
    case (sz)
      2'b00: begin
        case (lo)
          2'b00:   res[7:0]   = new_v[7:0];
          2'b01:   res[15:8]  = new_v[7:0];
          2'b10:   res[23:16] = new_v[7:0];
          2'b11:   res[31:24] = new_v[7:0];
          default: res        = old_w;
        endcase
      end
      2'b01: begin
        if (lo[1]) res[31:16] = new_v[15:0];
        else       res[15:0]  = new_v[15:0];
      end
      default: res = new_v;
    endcase
    return res;
  endfunction

  // True when the narrowed value sign/zero-extends back to the full register value.
  function automatic logic trunc_check(input logic [31:0] w,
                                       input logic [1:0]  sz,
                                       input logic        ext,
                                       input logic        mis);
    logic ok;
    if (mis) begin
      ok = 1'b0;
    end else begin
      case (sz)
        2'b00:   ok = ext ? ((&w[31:7])  | ~(|w[31:7]))  : ~(|w[31:8]);
        2'b01:   ok = ext ? ((&w[31:15]) | ~(|w[31:15])) : ~(|w[31:16]);
        2'b10:   ok = 1'b1;
        default: ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

  // Alignment check on the incoming request; reserved size counts as misaligned.
  always_comb begin
    misal_s = 1'b0;
    if ((size == 2'b01 && addr[0]) ||
        (size == 2'b10 && addr[1:0] != 2'b00) ||
        (size == 2'b11)) begin
      misal_s = 1'b1;
    end else begin
      misal_s = 1'b0;
    end
  end

  // Next-state logic of the store FSM.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (req) begin
          if (misal_s)              state_nx_s = S_ERR;
          else if (size == 2'b10)   state_nx_s = S_WR;
          else                      state_nx_s = S_RD;
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_RD:    state_nx_s = S_MRG;
      S_MRG:   state_nx_s = S_WR;
      S_WR:    state_nx_s = S_IDLE;
      S_ERR:   state_nx_s = S_IDLE;
      default: state_nx_s = S_IDLE;
    endcase
  end

  // State, request capture, merge datapath and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= S_IDLE;
      addr_lo_r  <= 2'b00;
      wdata_r    <= 32'h0000_0000;
      size_r     <= 2'b00;
      extop_r    <= 1'b0;
      misal_r    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      misaligned <= 1'b0;
      trunc_ok   <= 1'b0;
      mem_addr   <= '0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_wdata  <= 32'h0000_0000;
    end else begin
      state_r <= state_nx_s;
      busy    <= (state_nx_s != S_IDLE);
      mem_rd  <= (state_nx_s == S_RD);
      mem_wr  <= (state_nx_s == S_WR);
      done    <= (state_r == S_WR) || (state_r == S_ERR);
      if (state_r == S_IDLE && req) begin
        addr_lo_r <= addr[1:0];
        wdata_r   <= wdata;
        size_r    <= size;
        extop_r   <= ExtOp;
        misal_r   <= misal_s;
        mem_addr  <= addr[ADDR_W+1:2];
        if (size == 2'b10 && !misal_s) mem_wdata <= wdata;
      end
      // mem_rdata is only meaningful here, one cycle after the read strobe.
      if (state_r == S_MRG) begin
        mem_wdata <= merge_lane(mem_rdata, wdata_r, size_r, addr_lo_r);
      end
      if (state_r == S_WR || state_r == S_ERR) begin
        misaligned <= misal_r;
        trunc_ok   <= trunc_check(wdata_r, size_r, extop_r, misal_r);
      end
    end
  end

endmodule

// File: tb/tb_store_narrow_unit.sv
// Self-checking bench for store_narrow_unit: vector table plus reset/busy sequences.
module tb_store_narrow_unit;

  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req;
  logic [31:0]       addr;
  logic [31:0]       wdata;
  logic [1:0]        size;
  logic              ExtOp;
  logic              busy;
  logic              done;
  logic              misaligned;
  logic              trunc_ok;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [31:0]       mem_rdata;
  logic              mem_wr;
  logic [31:0]       mem_wdata;

  logic [31:0] mem [0:1023];

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        extop;
    logic [31:0] init;
    logic [31:0] exp_w;
    logic        exp_trunc;
    logic        exp_mis;
    int          exp_lat;
  } vec_t;

  vec_t vecs [11];

  store_narrow_unit #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .addr(addr), .wdata(wdata), .size(size),
    .ExtOp(ExtOp), .busy(busy), .done(done), .misaligned(misaligned), .trunc_ok(trunc_ok),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory; returns junk when not reading so late sampling is caught.
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem[mem_addr];
    else        mem_rdata <= 32'hDEAD_0000;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int cyc;
    int nrd;
    int nwr;
    logic [31:0] wd;
    logic [31:0] wa;
    logic [31:0] word;
    logic got_done;
    logic mis;
    logic tr;
    word = (v.addr >> 2) & 32'h0000_03FF;
    mem[word] = v.init;
    @(negedge clk);
    req = 1'b1; addr = v.addr; wdata = v.wdata; size = v.size; ExtOp = v.extop;
    @(negedge clk);
    req = 1'b0;
    cyc = 1; nrd = 0; nwr = 0; wd = 32'h0; wa = 32'h0;
    got_done = 1'b0; mis = 1'b0; tr = 1'b0;
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    while (cyc <= 12 && !got_done) begin
      if (mem_rd) nrd++;
      if (mem_wr) begin nwr++; wd = mem_wdata; wa = {22'd0, mem_addr}; end
      if (done) begin
        got_done = 1'b1; mis = misaligned; tr = trunc_ok;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    chk({tag, "_latency"}, cyc, v.exp_lat);
    chk({tag, "_misaligned"}, {31'd0, mis}, {31'd0, v.exp_mis});
    chk({tag, "_trunc_ok"}, {31'd0, tr}, {31'd0, v.exp_trunc});
    chk({tag, "_rd_count"}, nrd, (v.exp_mis || v.size == 2'b10) ? 32'd0 : 32'd1);
    chk({tag, "_wr_count"}, nwr, v.exp_mis ? 32'd0 : 32'd1);
    if (!v.exp_mis) begin
      chk({tag, "_wdata"}, wd, v.exp_w);
      chk({tag, "_waddr"}, wa, word);
      mem[word] = wd;
    end
    @(negedge clk);
    chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int nwr;
    vecs[0]  = '{2'b00, 32'h16, 32'h0000_0011, 1'b0, 32'hAABB_CCDD, 32'hAA11_CCDD, 1'b1, 1'b0, 4};
    vecs[1]  = '{2'b01, 32'h0A, 32'hFFFF_8000, 1'b1, 32'h1234_5678, 32'h8000_5678, 1'b1, 1'b0, 4};
    vecs[2]  = '{2'b01, 32'h0A, 32'hFFFF_8000, 1'b0, 32'h1234_5678, 32'h8000_5678, 1'b0, 1'b0, 4};
    vecs[3]  = '{2'b10, 32'h20, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000, 32'hDEAD_BEEF, 1'b1, 1'b0, 2};
    vecs[4]  = '{2'b01, 32'h03, 32'h0000_0001, 1'b0, 32'h5555_5555, 32'h0000_0000, 1'b0, 1'b1, 2};
    vecs[5]  = '{2'b10, 32'h06, 32'h0000_0001, 1'b0, 32'h5555_5555, 32'h0000_0000, 1'b0, 1'b1, 2};
    vecs[6]  = '{2'b11, 32'h00, 32'h0000_0001, 1'b0, 32'h5555_5555, 32'h0000_0000, 1'b0, 1'b1, 2};
    vecs[7]  = '{2'b00, 32'h03, 32'hFFFF_FF80, 1'b1, 32'h0000_0000, 32'h8000_0000, 1'b1, 1'b0, 4};
    vecs[8]  = '{2'b00, 32'h01, 32'h0000_0180, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_80FF, 1'b0, 1'b0, 4};
    vecs[9]  = '{2'b01, 32'h04, 32'h0000_7FFF, 1'b1, 32'hAAAA_AAAA, 32'hAAAA_7FFF, 1'b1, 1'b0, 4};
    vecs[10] = '{2'b00, 32'h00, 32'h0000_007F, 1'b1, 32'h1122_3344, 32'h1122_337F, 1'b1, 1'b0, 4};

    rst_n = 1'b0; req = 1'b0; addr = 32'h0; wdata = 32'h0; size = 2'b00; ExtOp = 1'b0;
    #1;
    chk("reset_outputs", {25'd0, busy, done, misaligned, trunc_ok, mem_rd, mem_wr, 1'b0},
        32'd0);
    chk("reset_mem_addr", {22'd0, mem_addr}, 32'd0);
    chk("reset_mem_wdata", mem_wdata, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset asserted while the byte store sits in MRG must abort without a write.
    mem[5] = 32'hAABB_CCDD;
    @(negedge clk);
    req = 1'b1; addr = 32'h16; wdata = 32'h0000_0022; size = 2'b00; ExtOp = 1'b0;
    @(negedge clk);
    req = 1'b0;
    chk("abort_rd_strobe", {31'd0, mem_rd}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_outputs", {26'd0, busy, done, misaligned, trunc_ok, mem_rd, mem_wr}, 32'd0);
    chk("abort_mem_wdata", mem_wdata, 32'd0);
    chk("abort_mem_addr", {22'd0, mem_addr}, 32'd0);
    nwr = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 2) rst_n = 1'b1;
      if (mem_wr || done || busy) nwr++;
    end
    chk("abort_no_activity", nwr, 32'd0);
    run_vec(vecs[0], "after_abort");

    // Requests while busy are dropped; a request in the done cycle is taken.
    mem[5] = 32'hAABB_CCDD;
    @(negedge clk);
    req = 1'b1; addr = 32'h16; wdata = 32'h0000_0011; size = 2'b00; ExtOp = 1'b0;
    @(negedge clk);
    addr = 32'h40; wdata = 32'hCAFE_F00D; size = 2'b10;
    nwr = 0;
    for (int c = 1; c <= 3; c++) begin
      if (mem_wr) begin
        nwr++;
        chk("busy_req_wdata", mem_wdata, 32'hAA11_CCDD);
        chk("busy_req_waddr", {22'd0, mem_addr}, 32'd5);
      end
      if (c == 3) req = 1'b0;
      @(negedge clk);
    end
    chk("busy_req_wr_count", nwr, 32'd1);
    chk("busy_req_done", {31'd0, done}, 32'd1);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    chk("done_cycle_req_wr", {31'd0, mem_wr}, 32'd1);
    chk("done_cycle_req_addr", {22'd0, mem_addr}, 32'd16);
    chk("done_cycle_req_wdata", mem_wdata, 32'hCAFE_F00D);
    @(negedge clk);
    chk("done_cycle_req_done", {30'd0, done, misaligned}, 32'd2);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
